// File: rtl/mandel_iter_pipe.sv
// mandel_iter_pipe: a chain of DEPTH Mandelbrot iteration stages (z <= z^2 + c)
// in signed fixed point. Each stage either passes an already-escaped point,
// marks a new escape when |z|^2 > 4.0, or performs one clamped iteration.
// A single global advance signal moves every stage together, so bubbles are
// carried along and the latency is always DEPTH cycles.
module mandel_iter_pipe #(
  parameter int W     = 16,
  parameter int FRAC  = 12,
  parameter int DEPTH = 4,
  parameter int ITW   = 8
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_x,
  input  logic [W-1:0]   in_y,
  input  logic [W-1:0]   in_cre,
  input  logic [W-1:0]   in_cim,
  input  logic [ITW-1:0] in_iter,
  input  logic           in_done,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_x,
  output logic [W-1:0]   out_y,
  output logic [W-1:0]   out_cre,
  output logic [W-1:0]   out_cim,
  output logic [ITW-1:0] out_iter,
  output logic           out_done,
  output logic           out_sat
);

  // Products and sums are held at 2W+2 bits so that x*x - y*y and 2*x*y
  // never overflow before the fractional shift.
  localparam int PW = 2 * W + 2;

  localparam logic signed [PW-1:0] MAXV  = PW'((2 ** (W - 1)) - 1);
  localparam logic signed [PW-1:0] MINV  = ~MAXV;
  localparam logic signed [PW-1:0] LIMIT = PW'(4) <<< (2 * FRAC);

  typedef struct packed {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W-1:0]   cre;
    logic [W-1:0]   cim;
    logic [ITW-1:0] iter;
    logic           done;
    logic           sat;
  } stage_t;

  stage_t           stage_q [DEPTH];
  stage_t           stage_d [DEPTH];
  stage_t           headIn;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic             advance;

  // Clamp a wide result into the W-bit signed range; the top bit of the
  // return value flags that clamping took place.
  function automatic logic [W:0] clampToW(input logic signed [PW-1:0] v);
    logic [W:0] r;
    if (v > MAXV) begin
      r = {1'b1, MAXV[W-1:0]};
    end else if (v < MINV) begin
      r = {1'b1, MINV[W-1:0]};
    end else begin
      r = {1'b0, v[W-1:0]};
    end
    return r;
  endfunction

  // One iteration stage: escaped points are untouched, points with
  // |z|^2 strictly above 4.0 are flagged as escaped with z and iter frozen,
  // everything else gets z^2 + c with floor rounding and a saturating count.
  function automatic stage_t iterate(input stage_t s);
    stage_t                  r;
    logic signed [PW-1:0]    xe;
    logic signed [PW-1:0]    ye;
    logic signed [PW-1:0]    xx;
    logic signed [PW-1:0]    yy;
    logic signed [PW-1:0]    mag2;
    logic signed [PW-1:0]    reFull;
    logic signed [PW-1:0]    imFull;
    logic [W:0]              reClamp;
    logic [W:0]              imClamp;
    r       = s;
    xe      = PW'($signed(s.x));
    ye      = PW'($signed(s.y));
    xx      = xe * xe;
    yy      = ye * ye;
    mag2    = xx + yy;
    reFull  = ((xx - yy) >>> FRAC) + PW'($signed(s.cre));
    imFull  = (((xe * ye) <<< 1) >>> FRAC) + PW'($signed(s.cim));
    reClamp = clampToW(reFull);
    imClamp = clampToW(imFull);
    if (!s.done) begin
      if (mag2 > LIMIT) begin
        r.done = 1'b1;
      end else begin
        r.x    = reClamp[W-1:0];
        r.y    = imClamp[W-1:0];
        r.iter = (s.iter == {ITW{1'b1}}) ? s.iter : s.iter + ITW'(1);
        r.sat  = s.sat | reClamp[W] | imClamp[W];
      end
    end
    return r;
  endfunction

  assign advance  = !valid_q[DEPTH-1] || out_ready;
  assign in_ready = advance;

  // Compute the next contents of every stage from the one before it; a new
  // pass always starts with a clear saturation flag.
  always_comb begin
    headIn.x    = in_x;
    headIn.y    = in_y;
    headIn.cre  = in_cre;
    headIn.cim  = in_cim;
    headIn.iter = in_iter;
    headIn.done = in_done;
    headIn.sat  = 1'b0;
    valid_d     = '0;
    stage_d[0]  = iterate(headIn);
    valid_d[0]  = in_valid;
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = iterate(stage_q[k-1]);
      valid_d[k] = valid_q[k-1];
    end
  end

  // Stage registers: cleared by reset, shifted as a whole on advance and
  // otherwise held so nothing is lost under back-pressure.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_x     = stage_q[DEPTH-1].x;
  assign out_y     = stage_q[DEPTH-1].y;
  assign out_cre   = stage_q[DEPTH-1].cre;
  assign out_cim   = stage_q[DEPTH-1].cim;
  assign out_iter  = stage_q[DEPTH-1].iter;
  assign out_done  = stage_q[DEPTH-1].done;
  assign out_sat   = stage_q[DEPTH-1].sat;

endmodule

// File: tb/tb_mandel_iter_pipe.sv
// tb_mandel_iter_pipe: directed vectors with hand-computed results for the
// default Q4.12, DEPTH=4 pipe, plus back-pressure and reset sequences.
module tb_mandel_iter_pipe;

  logic        Clk;
  logic        Rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_cre;
  logic [15:0] in_cim;
  logic [7:0]  in_iter;
  logic        in_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x;
  logic [15:0] out_y;
  logic [15:0] out_cre;
  logic [15:0] out_cim;
  logic [7:0]  out_iter;
  logic        out_done;
  logic        out_sat;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] cre;
    logic [15:0] cim;
    logic [7:0]  iter;
    logic        done;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [7:0]  eiter;
    logic        edone;
    logic        esat;
  } vec_t;

  vec_t vecs [9];

  mandel_iter_pipe dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_cre    (in_cre),
    .in_cim    (in_cim),
    .in_iter   (in_iter),
    .in_done   (in_done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_cre   (out_cre),
    .out_cim   (out_cim),
    .out_iter  (out_iter),
    .out_done  (out_done),
    .out_sat   (out_sat)
  );

  // Free-running clock.
  always #5 Clk = ~Clk;

  // Hard stop in case a sequence never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one point, wait for it to emerge and compare it with the table entry.
  task automatic applyStimulus(input vec_t v);
    int lat;
    in_x     = v.x;
    in_y     = v.y;
    in_cre   = v.cre;
    in_cim   = v.cim;
    in_iter  = v.iter;
    in_done  = v.done;
    in_valid = 1'b1;
    checkOutput({v.name, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge Clk);
      #1;
      lat++;
    end
    checkOutput({v.name, ".latency"}, 32'(lat), 32'd4);
    checkOutput({v.name, ".x"},    32'(out_x),    32'(v.ex));
    checkOutput({v.name, ".y"},    32'(out_y),    32'(v.ey));
    checkOutput({v.name, ".cre"},  32'(out_cre),  32'(v.cre));
    checkOutput({v.name, ".cim"},  32'(out_cim),  32'(v.cim));
    checkOutput({v.name, ".iter"}, 32'(out_iter), 32'(v.eiter));
    checkOutput({v.name, ".done"}, 32'(out_done), 32'(v.edone));
    checkOutput({v.name, ".sat"},  32'(out_sat),  32'(v.esat));
    @(posedge Clk);
    #1;
    checkOutput({v.name, ".drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int recv;
    int extra;
    logic inTake;
    logic outTake;
    logic prevStall;
    logic [15:0] heldCre;

    //          name        x        y        cre      cim      iter  done  ex       ey       eiter edone esat
    vecs[0] = '{"zero",     16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0,   1'b0, 16'h0000, 16'h0000, 8'd4,   1'b0, 1'b0};
    vecs[1] = '{"esc2",     16'h0000, 16'h0000, 16'h2000, 16'h0000, 8'd0,   1'b0, 16'h6000, 16'h0000, 8'd2,   1'b1, 1'b0};
    vecs[2] = '{"clampPos", 16'h2000, 16'h0000, 16'h7000, 16'h0000, 8'd5,   1'b0, 16'h7FFF, 16'h0000, 8'd6,   1'b1, 1'b1};
    vecs[3] = '{"passDone", 16'h1234, 16'hABCD, 16'h0111, 16'hFEDC, 8'd37,  1'b1, 16'h1234, 16'hABCD, 8'd37,  1'b1, 1'b0};
    vecs[4] = '{"iterSat",  16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd254, 1'b0, 16'h0000, 16'h0000, 8'd255, 1'b0, 1'b0};
    vecs[5] = '{"edge4",    16'h0000, 16'h0000, 16'hE000, 16'h0000, 8'd0,   1'b0, 16'h2000, 16'h0000, 8'd4,   1'b0, 1'b0};
    vecs[6] = '{"rotate",   16'h0000, 16'h0000, 16'h0000, 16'h1000, 8'd0,   1'b0, 16'hF000, 16'h1000, 8'd4,   1'b0, 1'b0};
    vecs[7] = '{"floorRnd", 16'h0000, 16'h0041, 16'h0000, 16'h7000, 8'd0,   1'b0, 16'hFFFE, 16'h7000, 8'd1,   1'b1, 1'b0};
    vecs[8] = '{"clampNeg", 16'h0000, 16'h2000, 16'h9000, 16'h0000, 8'd0,   1'b0, 16'h8000, 16'h0000, 8'd1,   1'b1, 1'b1};

    Clk       = 1'b0;
    Rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_cre    = '0;
    in_cim    = '0;
    in_iter   = '0;
    in_done   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;

    checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset.in_ready",  32'(in_ready),  32'd1);
    checkOutput("reset.out_x",     32'(out_x),     32'd0);
    checkOutput("reset.out_iter",  32'(out_iter),  32'd0);
    checkOutput("reset.flags",     32'({out_done, out_sat}), 32'd0);

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Back-pressure: six pass-through points streamed while out_ready drops
    // for ten cycles; they must leave in order, exactly once each.
    sent      = 0;
    recv      = 0;
    prevStall = 1'b0;
    heldCre   = '0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      out_ready = !(cyc >= 2 && cyc < 12);
      in_valid  = (sent < 6);
      in_x      = 16'(sent * 3);
      in_y      = 16'h0042;
      in_cre    = 16'h0100 + 16'(sent);
      in_cim    = 16'h0200;
      in_iter   = 8'(sent + 10);
      in_done   = 1'b1;
      @(negedge Clk);
      if (prevStall) begin
        checkOutput("bp.hold_valid", 32'(out_valid), 32'd1);
        checkOutput("bp.hold_cre",   32'(out_cre),   32'(heldCre));
      end
      if (out_valid && !out_ready) begin
        checkOutput("bp.in_ready_stalled", 32'(in_ready), 32'd0);
      end
      inTake  = in_valid && in_ready;
      outTake = out_valid && out_ready;
      if (outTake) begin
        checkOutput("bp.order_cre",  32'(out_cre),  32'(16'h0100 + 16'(recv)));
        checkOutput("bp.order_iter", 32'(out_iter), 32'(recv + 10));
        recv++;
      end
      prevStall = out_valid && !out_ready;
      heldCre   = out_cre;
      @(posedge Clk);
      #1;
      if (inTake) begin
        sent++;
      end
    end
    in_valid  = 1'b0;
    in_done   = 1'b0;
    out_ready = 1'b1;
    checkOutput("bp.sent", 32'(sent), 32'd6);
    checkOutput("bp.recv", 32'(recv), 32'd6);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (out_valid) begin
        extra++;
      end
    end
    checkOutput("bp.no_duplicates", 32'(extra), 32'd0);

    // Reset with three points in flight: they must all be discarded.
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_x     = 16'h0000;
      in_y     = 16'h0000;
      in_cre   = 16'h0A00 + 16'(i);
      in_cim   = 16'h0000;
      in_iter  = 8'd9;
      in_done  = 1'b1;
      @(posedge Clk);
      #1;
    end
    in_valid = 1'b0;
    in_done  = 1'b0;
    Rst      = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst.out_cre",   32'(out_cre),   32'd0);
    checkOutput("rst.out_iter",  32'(out_iter),  32'd0);
    checkOutput("rst.flags",     32'({out_done, out_sat}), 32'd0);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (out_valid) begin
        extra++;
      end
    end
    checkOutput("rst.discarded", 32'(extra), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
